// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/mult-div stalls,
// fetch/decode flushes and the HI/LO latency tracker for the mult/div unit.
module hazard_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] write_reg_e,
    input  logic [4:0] write_reg_m,
    input  logic [4:0] write_reg_w,
    input  logic       reg_write_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       mem_to_reg_e,
    input  logic       mem_to_reg_m,
    input  logic       branch_d,
    input  logic       jump_d,
    input  logic       pc_src_d,
    input  logic       md_d,
    input  logic       md_start_e,
    input  logic       md_is_div_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_t;

    localparam logic [4:0] MULT_CNT = 5'(MULT_LAT - 2);
    localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT - 2);

    md_state_t  state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [4:0] load_cnt;
    logic       load_use, br_stall, md_stall, stall;

    // r0 is hardwired to zero, so it can never create a dependency
    function automatic logic hit(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       en
    );
        return en && (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        fwd_a_e = 2'b00;
        priority case (1'b1)
            hit(rs_e, write_reg_m, reg_write_m): fwd_a_e = 2'b10;
            hit(rs_e, write_reg_w, reg_write_w): fwd_a_e = 2'b01;
            default:                             fwd_a_e = 2'b00;
        endcase
    end

    always_comb begin
        fwd_b_e = 2'b00;
        priority case (1'b1)
            hit(rt_e, write_reg_m, reg_write_m): fwd_b_e = 2'b10;
            hit(rt_e, write_reg_w, reg_write_w): fwd_b_e = 2'b01;
            default:                             fwd_b_e = 2'b00;
        endcase
    end

    assign fwd_a_d = hit(rs_d, write_reg_m, reg_write_m);
    assign fwd_b_d = hit(rt_d, write_reg_m, reg_write_m);

    assign load_use = hit(rs_d, write_reg_e, mem_to_reg_e)
                   || hit(rt_d, write_reg_e, mem_to_reg_e);

    assign br_stall = branch_d
                   && (hit(rs_d, write_reg_e, reg_write_e)
                    || hit(rt_d, write_reg_e, reg_write_e)
                    || hit(rs_d, write_reg_m, mem_to_reg_m)
                    || hit(rt_d, write_reg_m, mem_to_reg_m));

    assign md_stall = md_d && (md_busy || md_start_e);
    assign stall    = load_use || br_stall || md_stall;

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;
    // a stalled branch is re-evaluated next cycle, so it must not flush yet
    assign flush_d = (pc_src_d || jump_d) && !stall;

    assign load_cnt = md_is_div_e ? DIV_CNT : MULT_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // counter holds the BUSY cycles left before the DONE strobe
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE, DONE: begin
                if (md_start_e) begin
                    cnt_n   = load_cnt;
                    state_n = (load_cnt == 5'd0) ? DONE : BUSY;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                cnt_n = (cnt == 5'd0) ? 5'd0 : cnt - 5'd1;
                if (cnt <= 5'd1) state_n = DONE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 5'd0;
            end
        endcase
    end

    assign md_busy = (state != IDLE);
    assign md_done = (state == DONE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a cycle-index
// model of the mult/div unit and the forwarding/stall rules.
module tb_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, jump_d, pc_src_d;
    logic       md_d, md_start_e, md_is_div_e;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic       fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       md_busy, md_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int md_st = -1;
    int md_end = -1;

    hazard_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .rs_e        (rs_e),
        .rt_e        (rt_e),
        .write_reg_e (write_reg_e),
        .write_reg_m (write_reg_m),
        .write_reg_w (write_reg_w),
        .reg_write_e (reg_write_e),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .mem_to_reg_e(mem_to_reg_e),
        .mem_to_reg_m(mem_to_reg_m),
        .branch_d    (branch_d),
        .jump_d      (jump_d),
        .pc_src_d    (pc_src_d),
        .md_d        (md_d),
        .md_start_e  (md_start_e),
        .md_is_div_e (md_is_div_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .fwd_a_d     (fwd_a_d),
        .fwd_b_d     (fwd_b_d),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e),
        .md_busy     (md_busy),
        .md_done     (md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic bit hit(input logic [4:0] s, input logic [4:0] d,
                               input logic en);
        return en && (s != 5'd0) && (s == d);
    endfunction

    task automatic clear_inputs();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_to_reg_e = 0; mem_to_reg_m = 0;
        branch_d = 0; jump_d = 0; pc_src_d = 0;
        md_d = 0; md_start_e = 0; md_is_div_e = 0;
    endtask

    task automatic rand_inputs();
        rs_d = 5'($urandom_range(0, 3));
        rt_d = 5'($urandom_range(0, 3));
        rs_e = 5'($urandom_range(0, 3));
        rt_e = 5'($urandom_range(0, 3));
        write_reg_e = 5'($urandom_range(0, 3));
        write_reg_m = 5'($urandom_range(0, 3));
        write_reg_w = 5'($urandom_range(0, 3));
        reg_write_e = 1'($urandom);
        reg_write_m = 1'($urandom);
        reg_write_w = 1'($urandom);
        mem_to_reg_e = ($urandom_range(0, 2) == 0);
        mem_to_reg_m = ($urandom_range(0, 2) == 0);
        branch_d = ($urandom_range(0, 2) == 0);
        jump_d = ($urandom_range(0, 4) == 0);
        pc_src_d = 1'($urandom);
        md_d = ($urandom_range(0, 2) == 0);
        md_start_e = ($urandom_range(0, 5) == 0);
        md_is_div_e = 1'($urandom);
    endtask

    task automatic check_all();
        bit busy, done, lu, br, mds, st;
        logic [1:0] fa, fb;
        busy = (md_st >= 0) && (cyc > md_st) && (cyc <= md_end);
        done = (md_end >= 0) && (cyc == md_end);
        lu = hit(rs_d, write_reg_e, mem_to_reg_e)
          || hit(rt_d, write_reg_e, mem_to_reg_e);
        br = branch_d && (hit(rs_d, write_reg_e, reg_write_e)
                       || hit(rt_d, write_reg_e, reg_write_e)
                       || hit(rs_d, write_reg_m, mem_to_reg_m)
                       || hit(rt_d, write_reg_m, mem_to_reg_m));
        mds = md_d && (busy || md_start_e);
        st = lu || br || mds;
        fa = hit(rs_e, write_reg_m, reg_write_m) ? 2'b10 :
             hit(rs_e, write_reg_w, reg_write_w) ? 2'b01 : 2'b00;
        fb = hit(rt_e, write_reg_m, reg_write_m) ? 2'b10 :
             hit(rt_e, write_reg_w, reg_write_w) ? 2'b01 : 2'b00;
        chk("stall_f", 32'(stall_f), 32'(st));
        chk("stall_d", 32'(stall_d), 32'(st));
        chk("flush_e", 32'(flush_e), 32'(st));
        chk("flush_d", 32'(flush_d), 32'((pc_src_d || jump_d) && !st));
        chk("fwd_a_d", 32'(fwd_a_d), 32'(hit(rs_d, write_reg_m, reg_write_m)));
        chk("fwd_b_d", 32'(fwd_b_d), 32'(hit(rt_d, write_reg_m, reg_write_m)));
        chk("fwd_a_e", 32'(fwd_a_e), 32'(fa));
        chk("fwd_b_e", 32'(fwd_b_e), 32'(fb));
        chk("md_busy", 32'(md_busy), 32'(busy));
        chk("md_done", 32'(md_done), 32'(done));
    endtask

    // check the current cycle, then advance the model across one edge
    task automatic cycle_check();
        bit in_busy;
        #1;
        check_all();
        @(posedge clk);
        in_busy = (md_st >= 0) && (cyc > md_st) && (cyc < md_end);
        if (md_start_e && !in_busy) begin
            md_st = cyc;
            md_end = cyc + (md_is_div_e ? DIV_LAT : MULT_LAT) - 1;
        end
        cyc++;
        #1;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        #1;
        md_st = -1;
        md_end = -1;
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_done", 32'(md_done), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        md_start_e = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(md_busy), 32'd0);
        chk("reset_done", 32'(md_done), 32'd0);
        clear_inputs();
        rst = 1'b0;
        cyc = 0;

        // forwarding priority and r0 exclusion
        write_reg_m = 8; reg_write_m = 1;
        write_reg_w = 8; reg_write_w = 1; rs_e = 8;
        #1;
        chk("dir_fwd_m", 32'(fwd_a_e), 32'd2);
        cycle_check();
        clear_inputs();
        reg_write_m = 1;
        #1;
        chk("dir_fwd_r0", 32'(fwd_a_e), 32'd0);
        cycle_check();

        // load-use then release
        clear_inputs();
        mem_to_reg_e = 1; write_reg_e = 9; rt_d = 9;
        #1;
        chk("dir_lu_stall", 32'(stall_d), 32'd1);
        chk("dir_lu_flushd", 32'(flush_d), 32'd0);
        cycle_check();
        mem_to_reg_e = 0;
        #1;
        chk("dir_lu_clear", 32'(stall_f), 32'd0);
        cycle_check();

        // taken branch waiting on E result, then resolving
        clear_inputs();
        branch_d = 1; pc_src_d = 1; reg_write_e = 1;
        write_reg_e = 4; rs_d = 4;
        #1;
        chk("dir_br_stall", 32'(stall_d), 32'd1);
        chk("dir_br_noflush", 32'(flush_d), 32'd0);
        cycle_check();
        reg_write_e = 0;
        #1;
        chk("dir_br_flush", 32'(flush_d), 32'd1);
        chk("dir_br_go", 32'(stall_d), 32'd0);
        cycle_check();

        // mult issue with a dependent mfhi waiting in D
        clear_inputs();
        md_start_e = 1; md_d = 1;
        #1;
        chk("dir_mul_stall0", 32'(stall_d), 32'd1);
        cycle_check();
        for (int k = 1; k <= 6; k++) begin
            md_start_e = 0;
            #1;
            chk("dir_mul_busy", 32'(md_busy), 32'(k <= 4));
            chk("dir_mul_done", 32'(md_done), 32'(k == 4));
            chk("dir_mul_stall", 32'(stall_d), 32'(k <= 4));
            cycle_check();
        end

        // div aborted by reset at cycle 6, then a clean mult
        clear_inputs();
        md_start_e = 1; md_is_div_e = 1;
        cycle_check();
        md_start_e = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) rst_pulse();
            if (k == 10) md_start_e = 1;
            else md_start_e = 0;
            md_is_div_e = 0;
            cycle_check();
        end

        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            if ($urandom_range(0, 49) == 0) rst_pulse();
            cycle_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, cycles from mult issue in E to HI/LO write (legal range 2..31).
REQ-002 Parameter DIV_LAT, default 12, cycles from div issue in E to HI/LO write (legal range 2..31).
REQ-003 clk  in  1  rising-edge clock shared with all pipeline registers.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 rs_d, rt_d  in  5 each  source registers of the D-stage instruction.
REQ-006 rs_e, rt_e  in  5 each  source registers of the E-stage instruction.
REQ-007 write_reg_e, write_reg_m, write_reg_w  in  5 each  destination registers in E/M/W.
REQ-008 reg_write_e, reg_write_m, reg_write_w  in  1 each  destination write enable in E/M/W.
REQ-009 mem_to_reg_e, mem_to_reg_m  in  1 each  E/M instruction is a load.
REQ-010 branch_d, jump_d, pc_src_d  in  1 each  D holds a branch; D holds a jump; branch taken.
REQ-011 md_d  in  1  D holds mult, div, mfhi or mflo.
REQ-012 md_start_e, md_is_div_e  in  1 each  E issues a mult/div; 1 = div, 0 = mult.
REQ-013 stall_f, stall_d  out  1 each  hold PC / hold FD register (FD haz_enable = ~stall_d).
REQ-014 flush_d, flush_e  out  1 each  clear FD register (sig_clr) / clear DE register.
REQ-015 fwd_a_d, fwd_b_d  out  1 each  forward ALU result from M to branch comparator inputs.
REQ-016 fwd_a_e, fwd_b_e  out  2 each  E operand select: 00 regfile, 01 from W, 10 from M.
REQ-017 md_busy, md_done  out  1 each  mult/div unit busy; one-cycle HI/LO write strobe.

Function
REQ-018 Register 0 never matches any hazard or forwarding comparison.
REQ-019 fwd_a_e SHALL be 10 when rs_e==write_reg_m and reg_write_m; else 01 when rs_e==write_reg_w and reg_write_w; else 00; fwd_b_e same with rt_e.
REQ-020 fwd_a_d SHALL be 1 when rs_d==write_reg_m and reg_write_m; fwd_b_d same with rt_d.
REQ-021 Load-use stall: mem_to_reg_e and write_reg_e equal to rs_d or rt_d.
REQ-022 Branch stall: branch_d and ((reg_write_e and write_reg_e in {rs_d,rt_d}) or (mem_to_reg_m and write_reg_m in {rs_d,rt_d})).
REQ-023 MD stall: md_d and (md_busy or md_start_e).
REQ-024 stall_f = stall_d = flush_e = OR of REQ-021..023, combinational, same cycle.
REQ-025 flush_d = (pc_src_d or jump_d) and not stall_d; stall wins, branch re-evaluated next cycle.
REQ-026 MD FSM states IDLE, BUSY, DONE; counter 5 bits.
REQ-027 IDLE: md_start_e -> BUSY, counter loads (md_is_div_e ? DIV_LAT : MULT_LAT) - 2.
REQ-028 BUSY: counter decrements each cycle; at counter==0 -> DONE.
REQ-029 DONE: md_done=1 for exactly that cycle; next state IDLE, or BUSY with reload if md_start_e.
REQ-030 md_busy=1 in BUSY and DONE; md_start_e in BUSY is ignored (unreachable given REQ-023).
REQ-031 Latency: md_start_e in cycle N -> md_done high in cycle N+LAT-1, HI/LO readable by mfhi in D at N+LAT.

Reset
REQ-032 rst asserted: FSM IDLE, counter 0, md_busy=0, md_done=0 immediately, independent of clk.
REQ-033 rst mid-operation aborts any mult/div without md_done; combinational outputs remain functions of inputs during reset.
REQ-034 First md_start_e accepted on the first rising edge after rst deasserts.

Verification
REQ-035 write_reg_m=8, reg_write_m=1, write_reg_w=8, reg_write_w=1, rs_e=8 -> fwd_a_e=10; rs_e=0 with write_reg_m=0 -> 00.
REQ-036 mem_to_reg_e=1, write_reg_e=9, rt_d=9 -> stall_f=stall_d=flush_e=1, flush_d=0; next cycle E not load -> all 0.
REQ-037 branch_d=1, pc_src_d=1, reg_write_e=1, write_reg_e=rs_d=4 -> stall_d=1, flush_d=0; hazard cleared -> flush_d=1, stall_d=0.
REQ-038 md_start_e, md_is_div_e=0 at cycle 0 -> md_busy 1..4, md_done only at cycle 4; md_d=1 stalls cycles 0..4.
REQ-039 div issue (12 cycles), rst pulsed at cycle 6 -> md_busy=0 at once, md_done never asserts, next issue starts cleanly.
